// File: rtl/coin_balance_ctrl.sv
// coin_balance_ctrl: customer credit accumulator, inactivity timer
// and greedy one-coin-per-cycle change return for item_dispenser.
module coin_balance_ctrl #(
  parameter int kNumCoins   = 3,
  parameter int kTotalBits  = 31,
  parameter int kWaitTime   = 10,
  parameter int kMaxBalance = 10000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic                  i_trigger_return,
  input  logic [kTotalBits-1:0] cost,
  output logic [kTotalBits-1:0] balance,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic                  o_coin_reject,
  output logic                  o_busy
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StReturn = 1'b1;

  localparam int kTimerBits = $clog2(kWaitTime + 1);

  localparam logic [kTotalBits-1:0] kMaxBal =
    kTotalBits'(kMaxBalance);
  localparam logic [kTimerBits-1:0] kTimerLoad =
    kTimerBits'(kWaitTime);
  localparam logic [kTimerBits-1:0] kTimerOne =
    kTimerBits'(1);

  // Face value of each denomination; unknown slots are worthless.
  function automatic logic [kTotalBits-1:0] coin_value(
    input int idx
  );
    logic [kTotalBits-1:0] v;
    case (idx)
      0:       v = kTotalBits'(100);
      1:       v = kTotalBits'(500);
      2:       v = kTotalBits'(1000);
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [0:0]            state_q;
  logic [0:0]            state_d;
  logic [kTotalBits-1:0] bal_q;
  logic [kTotalBits-1:0] bal_d;
  logic [kTimerBits-1:0] timer_q;
  logic [kTimerBits-1:0] timer_d;

  logic [kTotalBits-1:0] ins_sum;
  logic [kTotalBits-1:0] ins_acc;
  logic [kTotalBits-1:0] sum_raw;
  logic [kTotalBits-1:0] ded;
  logic                  over_ceiling;
  logic                  activity;
  logic                  tick;
  logic                  go_return;
  logic                  reject;

  logic [kNumCoins-1:0]  ret_sel;
  logic [kTotalBits-1:0] ret_val;
  logic                  has_coin;

  // Total value of the coins presented this cycle.
  always_comb begin
    ins_sum = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (i_input_coin[i]) begin
        ins_sum = ins_sum + coin_value(i);
      end
    end
  end

  // Largest denomination that still fits in the held credit.
  always_comb begin
    ret_sel  = '0;
    ret_val  = '0;
    has_coin = 1'b0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (coin_value(i) != '0 &&
          coin_value(i) <= bal_q &&
          coin_value(i) > ret_val) begin
        ret_sel  = '0;
        ret_sel[i] = 1'b1;
        ret_val  = coin_value(i);
        has_coin = 1'b1;
      end
    end
  end

  // Credit bookkeeping, idle timer and return sequencing.
  always_comb begin
    state_d = state_q;
    bal_d   = bal_q;
    timer_d = timer_q;
    reject  = 1'b0;

    sum_raw      = bal_q + ins_sum;
    over_ceiling = sum_raw > kMaxBal;
    ins_acc      = over_ceiling ? '0 : ins_sum;
    // Overcharge cannot happen by contract; never underflow.
    ded          = (cost > bal_q) ? bal_q : cost;
    activity     = (ins_acc != '0) || (cost != '0);
    tick         = !activity && (bal_q != '0) &&
                   (timer_q != '0);
    go_return    = (bal_q != '0) &&
                   (i_trigger_return ||
                    (tick && timer_q == kTimerOne));

    unique case (state_q)
      StIdle: begin
        reject = over_ceiling && (ins_sum != '0);
        bal_d  = bal_q + ins_acc - ded;
        if (activity) begin
          timer_d = kTimerLoad;
        end else if (tick) begin
          timer_d = timer_q - kTimerOne;
        end
        if (go_return) begin
          state_d = StReturn;
          timer_d = '0;
        end
      end
      StReturn: begin
        reject  = |i_input_coin;
        timer_d = '0;
        if (!has_coin) begin
          // Residue smaller than any coin is forfeited.
          bal_d   = '0;
          state_d = StIdle;
        end else begin
          bal_d = bal_q - ret_val;
          if (ret_val == bal_q) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        bal_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      bal_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      timer_q <= timer_d;
    end
  end

  assign o_busy        = (state_q == StReturn);
  assign balance       = o_busy ? '0 : bal_q;
  assign o_return_coin = o_busy ? ret_sel : '0;
  assign o_coin_reject = reject;

endmodule

// File: tb/tb_coin_balance_ctrl.sv
// tb_coin_balance_ctrl: directed table vectors plus
// hand-written timeout and reset sequences.
module tb_coin_balance_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  i_input_coin;
  logic        i_trigger_return;
  logic [30:0] cost;
  logic [30:0] balance;
  logic [2:0]  o_return_coin;
  logic        o_coin_reject;
  logic        o_busy;

  int checks;
  int errors;

  typedef struct {
    bit         rst;
    logic [2:0] coin;
    bit         trig;
    int         cost;
    int         e_bal;
    logic [2:0] e_ret;
    bit         e_rej;
    bit         e_busy;
  } vec_t;

  vec_t vecs[$];

  coin_balance_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .i_input_coin     (i_input_coin),
    .i_trigger_return (i_trigger_return),
    .cost             (cost),
    .balance          (balance),
    .o_return_coin    (o_return_coin),
    .o_coin_reject    (o_coin_reject),
    .o_busy           (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  function automatic void add(
    input bit rst, input logic [2:0] coin,
    input bit trig, input int c,
    input int e_bal, input logic [2:0] e_ret,
    input bit e_rej, input bit e_busy
  );
    vec_t v;
    v.rst = rst; v.coin = coin; v.trig = trig;
    v.cost = c; v.e_bal = e_bal; v.e_ret = e_ret;
    v.e_rej = e_rej; v.e_busy = e_busy;
    vecs.push_back(v);
  endfunction

  initial begin
    int n;
    bit seen;
    checks = 0;
    errors = 0;

    // Each row: inputs for one cycle, outputs seen
    // before that cycle's rising edge.
    add(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    // insert 1000 then 500
    add(0, 3'b100, 0, 0, 0, 3'b000, 0, 0);
    add(0, 3'b010, 0, 0, 1000, 3'b000, 0, 0);
    add(0, 3'b000, 0, 0, 1500, 3'b000, 0, 0);
    // one sale of 500
    add(0, 3'b000, 0, 500, 1500, 3'b000, 0, 0);
    add(0, 3'b000, 0, 0, 1000, 3'b000, 0, 0);
    add(0, 3'b010, 0, 0, 1000, 3'b000, 0, 0);
    add(0, 3'b001, 0, 0, 1500, 3'b000, 0, 0);
    add(0, 3'b000, 0, 0, 1600, 3'b000, 0, 0);
    // manual return of 1600
    add(0, 3'b000, 1, 0, 1600, 3'b000, 0, 0);
    add(0, 3'b000, 0, 0, 0, 3'b100, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b010, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b001, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    // 700 via multi-hot, then timeout
    add(0, 3'b011, 0, 0, 0, 3'b000, 0, 0);
    add(0, 3'b001, 0, 0, 600, 3'b000, 0, 0);
    for (int k = 0; k < 10; k++)
      add(0, 3'b000, 0, 0, 700, 3'b000, 0, 0);
    add(0, 3'b000, 0, 0, 0, 3'b010, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b001, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b001, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    // ceiling
    for (int k = 0; k < 9; k++)
      add(0, 3'b100, 0, 0, k * 1000, 3'b000, 0, 0);
    add(0, 3'b010, 0, 0, 9000, 3'b000, 0, 0);
    add(0, 3'b100, 0, 0, 9500, 3'b000, 1, 0);
    add(0, 3'b010, 0, 0, 9500, 3'b000, 0, 0);
    add(0, 3'b001, 0, 0, 10000, 3'b000, 1, 0);
    // overcharge clamps to zero
    add(0, 3'b000, 0, 20000, 10000, 3'b000, 0, 0);
    // return request with no credit
    add(0, 3'b000, 1, 0, 0, 3'b000, 0, 0);
    add(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    // coin+cost same cycle, coin on trigger cycle
    add(0, 3'b100, 0, 0, 0, 3'b000, 0, 0);
    add(0, 3'b010, 0, 300, 1000, 3'b000, 0, 0);
    add(0, 3'b001, 1, 0, 1200, 3'b000, 0, 0);
    add(0, 3'b010, 0, 0, 0, 3'b100, 1, 1);
    add(0, 3'b000, 0, 5000, 0, 3'b001, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b001, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b001, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    // residue of 50
    add(0, 3'b100, 0, 0, 0, 3'b000, 0, 0);
    add(0, 3'b000, 0, 50, 1000, 3'b000, 0, 0);
    add(0, 3'b000, 1, 0, 950, 3'b000, 0, 0);
    add(0, 3'b000, 0, 0, 0, 3'b010, 0, 1);
    for (int k = 0; k < 4; k++)
      add(0, 3'b000, 0, 0, 0, 3'b001, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    // reset in the middle of a return
    add(0, 3'b100, 0, 0, 0, 3'b000, 0, 0);
    add(0, 3'b100, 0, 0, 1000, 3'b000, 0, 0);
    add(0, 3'b000, 1, 0, 2000, 3'b000, 0, 0);
    add(0, 3'b001, 0, 0, 0, 3'b100, 1, 1);
    add(1, 3'b000, 0, 0, 0, 3'b100, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    add(0, 3'b001, 0, 0, 0, 3'b000, 0, 0);
    add(0, 3'b000, 0, 0, 100, 3'b000, 0, 0);

    reset = 1'b1;
    i_input_coin = '0;
    i_trigger_return = 1'b0;
    cost = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      i_input_coin = vecs[i].coin;
      i_trigger_return = vecs[i].trig;
      cost = 31'(vecs[i].cost);
      #1;
      check($sformatf("row%0d balance", i),
            int'(balance), vecs[i].e_bal);
      check($sformatf("row%0d return", i),
            int'(o_return_coin), int'(vecs[i].e_ret));
      check($sformatf("row%0d reject", i),
            int'(o_coin_reject), int'(vecs[i].e_rej));
      check($sformatf("row%0d busy", i),
            int'(o_busy), int'(vecs[i].e_busy));
    end

    // fresh reset, then time a lone 100 to its refund
    @(negedge clk);
    reset = 1'b1;
    i_input_coin = '0;
    i_trigger_return = 1'b0;
    cost = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-reset balance", int'(balance), 0);
    check("post-reset busy", int'(o_busy), 0);
    i_input_coin = 3'b001;
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      i_input_coin = '0;
      #1;
      if (o_busy) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    check("timeout seen", int'(seen), 1);
    check("timeout cycles", n, 10);
    check("timeout coin", int'(o_return_coin), 1);
    check("timeout balance", int'(balance), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("after refund busy", int'(o_busy), 0);
    check("after refund balance", int'(balance), 0);
    check("after refund coin", int'(o_return_coin), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
